// File: rtl/integral_image_builder_if.sv
// rtl/integral_image_builder_if.sv - pixel-in / integral-word-out handshake bundle
interface integral_image_builder_if #(
    parameter int PIX_W  = 8,
    parameter int SUM_W  = 32,
    parameter int ADDR_W = 20
);
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output pix_valid, pix_data, out_ready,
        input  pix_ready, out_valid, out_data, out_addr, out_last
    );

    modport slave (
        input  pix_valid, pix_data, out_ready,
        output pix_ready, out_valid, out_data, out_addr, out_last
    );
endinterface

// File: rtl/integral_image_builder.sv
// rtl/integral_image_builder.sv - streaming summed-area table writer for one square core tile
module integral_image_builder #(
    parameter int PIX_W    = 8,
    parameter int SUM_W    = 32,
    parameter int MAX_SIDE = 1024,
    parameter int ADDR_W   = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            side,
    integral_image_builder_if.slave bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err
);
    localparam int XW = $clog2(MAX_SIDE + 1);
    localparam int LW = (MAX_SIDE > 1) ? $clog2(MAX_SIDE) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [XW-1:0]     side_r;
    logic [XW-1:0]     x;
    logic [XW-1:0]     y;
    logic [ADDR_W-1:0] base;
    logic [SUM_W-1:0]  rs;
    logic [SUM_W-1:0]  lb [0:MAX_SIDE-1];

    logic              side_ok;
    logic              accept;
    logic              consume;
    logic              x_end;
    logic              y_end;
    logic [SUM_W-1:0]  rs_next;
    logic [SUM_W-1:0]  lb_rd;
    logic [SUM_W-1:0]  ii;

    assign side_ok       = (side != 32'd0) && (side <= 32'(MAX_SIDE));
    assign bus.pix_ready = (state == S_RUN) && (!bus.out_valid || bus.out_ready);
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign consume       = bus.out_valid && bus.out_ready;
    assign x_end         = (x == side_r - 1'b1);
    assign y_end         = (y == side_r - 1'b1);
    assign busy          = (state != S_IDLE);

    // lb holds the previous row's integral values; read before this cycle's write
    assign lb_rd   = lb[x[LW-1:0]];
    assign rs_next = ((x == '0) ? '0 : rs) + SUM_W'(bus.pix_data);
    assign ii      = rs_next + ((y == '0) ? '0 : lb_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            side_r        <= '0;
            x             <= '0;
            y             <= '0;
            base          <= '0;
            rs            <= '0;
            frame_done    <= 1'b0;
            err           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_addr  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (side_ok) begin
                            side_r <= side[XW-1:0];
                            x      <= '0;
                            y      <= '0;
                            base   <= '0;
                            rs     <= '0;
                            state  <= S_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        rs <= rs_next;
                        if (x_end) begin
                            x    <= '0;
                            y    <= y + 1'b1;
                            base <= base + ADDR_W'(side_r);
                        end else begin
                            x <= x + 1'b1;
                        end
                        if (x_end && y_end) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (consume) begin
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // single output register: a new word may replace the one being consumed
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= ii;
                bus.out_addr  <= base + ADDR_W'(x);
                bus.out_last  <= x_end && y_end;
            end else if (consume) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb[x[LW-1:0]] <= ii;
        end
    end
endmodule

// File: tb/tb_integral_image_builder.sv
// tb/tb_integral_image_builder.sv - randomized bench with summed-area reference model
module tb_integral_image_builder;
    localparam int MAXS = 64;
    localparam int AW   = 12;

    typedef struct {
        logic [31:0]   data;
        logic [AW-1:0] addr;
        bit            last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] side = 32'd0;
    logic        busy, frame_done, err;

    integral_image_builder_if #(.PIX_W(8), .SUM_W(32), .ADDR_W(AW)) bus ();

    integral_image_builder #(.PIX_W(8), .SUM_W(32), .MAX_SIDE(MAXS), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .side       (side),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int fd_count = 0;
    int err_count = 0;

    exp_t        exp_q[$];
    int          pix[$];
    logic [31:0] model_data[$];
    logic [AW-1:0] model_last_addr;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) bus.out_ready = 1'b1;
        else if (ready_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    bit            exp_fd = 0;
    bit            exp_err = 0;
    bit            held = 0;
    logic [31:0]   h_data;
    logic [AW-1:0] h_addr;
    logic          h_last;

    always @(negedge clk) begin
        if (reset) begin
            chk({bus.out_valid, bus.out_data, bus.out_addr, bus.out_last, bus.pix_ready,
                 busy, frame_done, err} == '0, "reset_outputs_zero", {bus.out_valid, busy, err}, 0);
            exp_q.delete();
            exp_fd = 0;
            exp_err = 0;
            held = 0;
        end else begin
            chk(frame_done == exp_fd, "frame_done", frame_done, exp_fd);
            chk(err == exp_err, "err", err, exp_err);
            if (frame_done) fd_count++;
            if (err) err_count++;
            exp_fd = 0;
            exp_err = start && !busy && (side == 0 || side > MAXS);
            if (!busy) chk(bus.pix_ready == 0, "pix_ready_idle", bus.pix_ready, 0);
            if (held) begin
                chk(bus.out_valid == 1, "hold_valid", bus.out_valid, 1);
                chk(bus.out_data == h_data, "hold_data", bus.out_data, h_data);
                chk(bus.out_addr == h_addr, "hold_addr", bus.out_addr, h_addr);
                chk(bus.out_last == h_last, "hold_last", bus.out_last, h_last);
            end
            held = 0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk(0, "unexpected_word", bus.out_addr, -1);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk(bus.out_data == e.data, "out_data", bus.out_data, e.data);
                        chk(bus.out_addr == e.addr, "out_addr", bus.out_addr, e.addr);
                        chk(bus.out_last == e.last, "out_last", bus.out_last, e.last);
                        if (e.last) exp_fd = 1;
                    end
                end else begin
                    held = 1;
                    h_data = bus.out_data;
                    h_addr = bus.out_addr;
                    h_last = bus.out_last;
                    chk(bus.pix_ready == 0, "pix_ready_stall", bus.pix_ready, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int s);
        start = 1'b1;
        side  = s;
        tick();
        start = 1'b0;
    endtask

    // summed-area model: ii = p + up + left - upleft
    task automatic build_model(input int s);
        longint ii[];
        ii = new[s * s];
        model_data.delete();
        for (int yy = 0; yy < s; yy++) begin
            for (int xx = 0; xx < s; xx++) begin
                longint v;
                exp_t e;
                v = pix[yy * s + xx];
                if (xx > 0) v += ii[yy * s + xx - 1];
                if (yy > 0) v += ii[(yy - 1) * s + xx];
                if (xx > 0 && yy > 0) v -= ii[(yy - 1) * s + xx - 1];
                ii[yy * s + xx] = v;
                e.data = v[31:0];
                e.addr = AW'(yy * s + xx);
                e.last = (xx == s - 1) && (yy == s - 1);
                exp_q.push_back(e);
                model_data.push_back(v[31:0]);
                model_last_addr = e.addr;
            end
        end
    endtask

    task automatic run_frame(input int s, input int limit, input bit gaps, input bit mid_start);
        int n_pix;
        build_model(s);
        pulse_start(s);
        n_pix = (limit < s * s) ? limit : s * s;
        for (int k = 0; k < n_pix; k++) begin
            int  n;
            bit  acc;
            if (mid_start && k == s) begin
                bus.pix_valid = 1'b0;
                pulse_start(7);
                side = s;
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.pix_valid = 1'b0;
                tick();
            end
            bus.pix_valid = 1'b1;
            bus.pix_data  = pix[k][7:0];
            n = 0;
            acc = 0;
            do begin
                @(negedge clk);
                acc = bus.pix_ready;
                n++;
            end while (!acc && n < 2000);
            if (!acc) chk(0, "pixel_accept_timeout", k, n_pix);
            tick();
        end
        bus.pix_valid = 1'b0;
        if (n_pix == s * s) begin
            int  n;
            bit  seen;
            n = 0;
            seen = 0;
            while (!seen && n < 500) begin
                @(negedge clk);
                seen = frame_done;
                n++;
            end
            chk(seen, "frame_done_timeout", n, 500);
            chk(exp_q.size() == 0, "words_outstanding", exp_q.size(), 0);
            tick();
        end
    endtask

    task automatic fill(input int s, input int mode, input int val);
        pix.delete();
        for (int k = 0; k < s * s; k++) begin
            if (mode == 0) pix.push_back(val);
            else pix.push_back(int'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        int lit3[9];
        int lit2[4];
        int fd0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // side 3, all ones
        lit3 = '{1, 2, 3, 2, 4, 6, 3, 6, 9};
        fill(3, 0, 1);
        ready_mode = 0;
        run_frame(3, 1000, 0, 0);
        for (int k = 0; k < 9; k++) chk(model_data[k] == lit3[k], "model_side3", model_data[k], lit3[k]);
        chk(fd_count == 1, "frame_done_count", fd_count, 1);

        // side 2 with a 3-cycle downstream stall after the first word
        lit2 = '{10, 30, 40, 100};
        pix.delete();
        pix.push_back(10); pix.push_back(20); pix.push_back(30); pix.push_back(40);
        ready_mode = 2;
        bus.out_ready = 1'b0;
        fork
            run_frame(2, 1000, 0, 0);
            begin
                int n;
                n = 0;
                do begin @(negedge clk); n++; end while (!bus.out_valid && n < 100);
                chk(bus.out_data == 10, "stall_first_word", bus.out_data, 10);
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    chk(bus.pix_ready == 0, "stall_pix_ready", bus.pix_ready, 0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 4; k++) chk(model_data[k] == lit2[k], "model_side2", model_data[k], lit2[k]);
        ready_mode = 0;

        // largest tile, saturated pixels
        fill(MAXS, 0, 255);
        run_frame(MAXS, 100000, 0, 0);
        chk(model_data[MAXS * MAXS - 1] == 255 * MAXS * MAXS, "model_max_sum",
            model_data[MAXS * MAXS - 1], 255 * MAXS * MAXS);
        chk(model_last_addr == AW'(MAXS * MAXS - 1), "model_max_addr", model_last_addr, MAXS * MAXS - 1);

        // invalid sides
        err_count = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'd5;
        pulse_start(0);
        repeat (2) tick();
        pulse_start(MAXS + 1);
        repeat (3) tick();
        chk(err_count == 2, "err_pulses", err_count, 2);
        chk(busy == 0, "busy_after_err", busy, 0);
        chk(bus.out_valid == 0, "no_accept_after_err", bus.out_valid, 0);
        bus.pix_valid = 1'b0;

        // reset mid-frame, then a clean small frame
        fill(4, 1, 0);
        run_frame(4, 6, 0, 0);
        fd0 = fd_count;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk(fd_count == fd0, "no_fd_after_abort", fd_count, fd0);
        fill(2, 0, 1);
        run_frame(2, 1000, 0, 0);
        lit2 = '{1, 2, 2, 4};
        for (int k = 0; k < 4; k++) chk(model_data[k] == lit2[k], "model_after_abort", model_data[k], lit2[k]);

        // start during RUN is ignored
        fill(5, 1, 0);
        ready_mode = 1;
        run_frame(5, 1000, 1, 1);

        // randomized frames, including side 1
        fill(1, 1, 0);
        run_frame(1, 1000, 1, 0);
        for (int r = 0; r < 6; r++) begin
            int s;
            s = $urandom_range(1, 9);
            fill(s, 1, 0);
            ready_mode = $urandom_range(0, 1);
            run_frame(s, 1000, r[0], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/integral_image_builder.md
Name: integral_image_builder

Overview:
- Builds the integral image that the face-detection cores read as their `image` memory.
- Input: a raster-order stream of 8-bit grayscale pixels for one square core tile.
- Output: a raster-order stream of summed-area values with linear write addresses, written into the core tile memory.
- Sits between the tile splitter and each core; it is the writer for the core's integral-image reader.

Parameters:
- PIX_W, 8, pixel width.
- SUM_W, 32, integral value width; matches the core's 32-bit image words.
- MAX_SIDE, 1024, largest supported tile side (pixels); sizes the line buffer.
- ADDR_W, 20, output address width; must satisfy 2^ADDR_W >= MAX_SIDE*MAX_SIDE.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse that begins a frame; samples side
- side  in  32  tile side length in pixels (core uses 3*unit_size)
- pix_valid  in  1  pixel present
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- pix_data  in  PIX_W  pixel value, raster order, row-major
- out_valid  out  1  integral word present
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  SUM_W  ii(x,y) = sum of p(i,j) for i<=x, j<=y
- out_addr  out  ADDR_W  y*side + x
- out_last  out  1  high with the final word of the frame
- busy  out  1  high in RUN
- frame_done  out  1  one-cycle pulse after the last word is accepted downstream
- err  out  1  one-cycle pulse when start carries an invalid side

Behaviour:
- Reset state: all outputs 0, state IDLE, x/y counters 0, row accumulator 0. Line buffer contents are don't-care.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start with 1 <= side <= MAX_SIDE latches side_r, clears x, y and the row sum, and goes to RUN next cycle.
  - start with side == 0 or side > MAX_SIDE pulses err the next cycle and stays in IDLE.
  - pix_ready = 0.
- RUN:
  - pix_ready = !out_valid || out_ready (single output register, no skid).
  - On accept: rs_next = (x==0 ? 0 : rs) + pix_data, zero-extended to SUM_W.
  - Result: ii = rs_next + (y==0 ? 0 : lb[x]).
  - In the same cycle: lb[x] <= ii, rs <= rs_next.
  - Output register loads out_data=ii, out_addr=y*side_r+x, out_last=(x==side_r-1 && y==side_r-1). out_valid=1.
  - Line buffer is read combinationally at index x before the write; read-old semantics at the same index.
  - Counters: x increments; at x==side_r-1, x wraps to 0 and y increments.
  - Accepting the last pixel moves the FSM to DRAIN; pix_ready=0 from then on.
- Output hold: while out_valid && !out_ready, out_data, out_addr and out_last are held stable and no pixel is accepted.
- Latency: one cycle from pixel accept to out_valid. Full throughput of one word per clock when out_ready stays high.
- DRAIN: when the last word is accepted, out_valid drops, frame_done pulses one cycle, and the FSM returns to IDLE.
- busy = (state != IDLE).
- start while in RUN or DRAIN is ignored: no err, no relatch of side.
- Arithmetic: unsigned, modulo 2^SUM_W. With the defaults the maximum is 255*1024*1024 = 267386880, so no wrap occurs.
- out_addr: computed as (y*side_r + x) truncated to ADDR_W; the multiplier is allowed to be a registered running base (base += side_r at each row wrap).
- Asynchronous reset mid-frame aborts the frame immediately:
  - all outputs go to 0;
  - no frame_done pulse;
  - the next frame requires a new start.
- Simultaneous out_ready and pix_valid with out_valid set: the old word is consumed and the new word is loaded in the same cycle.

Test Plan:
- side=3, nine pixels all 1, out_ready=1 -> out_data 1,2,3,2,4,6,3,6,9; out_addr 0..8; out_last only on addr 8; frame_done exactly once, one cycle after that accept.
- side=2, pixels 10,20,30,40 with out_ready low for 3 cycles after the first word -> word 10 held stable, pix_ready=0 during the stall; final sequence 10,30,40,100.
- side=MAX_SIDE, all pixels 255 -> last out_data 267386880 at out_addr 1048575; no wrap.
- start with side=0, then start with side=1025 -> two err pulses, busy stays 0, no pixels accepted.
- start with side=4, reset asserted after 6 accepts, then start with side=2 and pixels 1,1,1,1 -> outputs 1,2,2,4; no stale line-buffer or row-sum effect; no frame_done from the aborted frame.
- start pulsed during RUN with side=7 -> ignored; frame completes with the original side, same addresses and count.
